memory_lbm_lattice: RTL and testbench

MEMORY_LBM_LATTICE -- requirements
Module: memory

---
 rtl/memory_lbm_lattice.sv | 324 ++++++++++++++++++++++++++++++++
 tb/tb_memory_lbm_lattice.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_lbm_lattice.sv
// D2Q9 lattice-Boltzmann solver with ping-pong distribution banks.
// One cell per cycle is read from the source bank. Its equilibrium (omega = 1) is streamed
// into the destination bank. The rho of the last completed bank drives a VGA colour map.
module memory_lbm_lattice #(
  parameter int unsigned NX   = 20,
  parameter int unsigned NY   = 15,
  parameter int unsigned FRAC = 13
) (
  input  logic       clk_50,
  input  logic       reset,
  input  logic [9:0] iCoord_X,
  input  logic [9:0] iCoord_Y,
  input  logic       vga_done,
  output logic [7:0] oRed,
  output logic [7:0] oGreen,
  output logic [7:0] oBlue
);

  localparam int unsigned NumCells = NX * NY;
  localparam int unsigned AddrW    = $clog2(NumCells);
  localparam int unsigned XW       = $clog2(NX);
  localparam int unsigned YW       = $clog2(NY);

  localparam logic [AddrW:0] LastCell = (AddrW + 1)'(NumCells - 1);
  localparam logic [AddrW:0] CellEnd  = (AddrW + 1)'(NumCells);
  localparam logic [XW-1:0]  LastX    = XW'(NX - 1);
  localparam logic [XW-1:0]  MidX     = XW'(NX / 2);
  localparam logic [YW-1:0]  LastY    = YW'(NY - 1);
  localparam logic [YW-1:0]  MidY     = YW'(NY / 2);

  typedef logic signed [17:0] val_t;

  // Direction vectors, y grows downward.
  localparam int EX [9] = '{0, 1, 0, -1, 0, 1, -1, -1, 1};
  localparam int EY [9] = '{0, 0, 1, 0, -1, 1, 1, -1, -1};
  // Lattice weights; these are also the distributions of a rest cell.
  localparam val_t W [9] = '{18'sd3641, 18'sd910, 18'sd910, 18'sd910, 18'sd910,
                             18'sd228, 18'sd228, 18'sd228, 18'sd228};
  // Initial distributions of the disturbed centre cell.
  localparam val_t Ctr [9] = '{18'sd5461, 18'sd1365, 18'sd1365, 18'sd1365, 18'sd1365,
                               18'sd341, 18'sd341, 18'sd341, 18'sd341};
  localparam val_t RhoRest = 18'sd8193;
  localparam val_t RhoCtr  = 18'sd12285;

  typedef enum logic [1:0] {StInit, StSolve, StWait} state_e;

  function automatic val_t sat18(input logic signed [47:0] v);
    if (v > 48'sd131071) begin
      return 18'sd131071;
    end else if (v < -48'sd131072) begin
      return -18'sd131072;
    end else begin
      return v[17:0];
    end
  endfunction

  function automatic logic [AddrW-1:0] cell_addr(input logic [XW-1:0] x,
                                                 input logic [YW-1:0] y);
    return AddrW'(32'(y) * NX + 32'(x));
  endfunction

  // Two banks, one RAM per direction, plus one rho RAM per bank.
  val_t f_mem   [2][9][NumCells];
  val_t rho_mem [2][NumCells];

  state_e            state_q, state_d;
  logic              src_q, src_d;
  logic              disp_q, disp_d;
  logic              pending_q, pending_d;
  logic [AddrW:0]    cnt_q, cnt_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic              adv;
  logic              issue;
  logic              pipe_busy;
  logic              dst;

  // Pipeline: read -> moments -> bracket -> equilibrium -> RAM write.
  logic              rd_vld_q, mom_vld_q, brk_vld_q, out_vld_q;
  logic [XW-1:0]     rd_x_q, mom_x_q, brk_x_q, out_x_q;
  logic [YW-1:0]     rd_y_q, mom_y_q, brk_y_q, out_y_q;
  val_t              rd_f_q [9];
  val_t              mom_rho_q, mom_jx_q, mom_jy_q;
  val_t              brk_rho_q, out_rho_q;
  val_t              brk_q [9];
  val_t              feq_q [9];

  logic signed [47:0] rho_w, jx_w, jy_w;
  logic signed [47:0] usq_w, t15_w, sq_w;
  val_t               ej_v;
  val_t               brk_d [9];
  val_t               feq_d [9];
  logic [AddrW-1:0]   st_addr [9];
  logic [XW-1:0]      sx;
  logic [YW-1:0]      sy;

  logic               in_range;
  logic [AddrW-1:0]   disp_addr;
  val_t               disp_rho;
  logic [7:0]         inten;

  assign issue     = (state_q == StSolve) && (cnt_q != CellEnd);
  assign pipe_busy = rd_vld_q | mom_vld_q | brk_vld_q | out_vld_q;
  assign dst       = ~src_q;

  // Sequencer state: phase, bank roles, pending step request and raster position.
  always_ff @(posedge clk_50 or negedge reset) begin
    if (!reset) begin
      state_q   <= StInit;
      src_q     <= 1'b0;
      disp_q    <= 1'b0;
      pending_q <= 1'b0;
      cnt_q     <= '0;
      x_q       <= '0;
      y_q       <= '0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      disp_q    <= disp_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      x_q       <= x_d;
      y_q       <= y_d;
    end
  end

  // Next-state: INIT fills bank A, SOLVE sweeps and drains, WAIT waits for a frame end.
  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    disp_d    = disp_q;
    pending_d = pending_q;
    cnt_d     = cnt_q;
    x_d       = x_q;
    y_d       = y_q;
    adv       = 1'b0;
    case (state_q)
      StInit: begin
        if (vga_done) pending_d = 1'b1;
        if (cnt_q == LastCell) begin
          state_d = StSolve;
          cnt_d   = '0;
          x_d     = '0;
          y_d     = '0;
        end else begin
          adv = 1'b1;
        end
      end
      StSolve: begin
        if (vga_done) pending_d = 1'b1;
        if (issue) begin
          adv = 1'b1;
        end else if (!pipe_busy) begin
          state_d = StWait;
          disp_d  = dst;
        end
      end
      StWait: begin
        // Any number of frame ends seen earlier collapse into this single step.
        if (vga_done || pending_q) begin
          pending_d = 1'b0;
          src_d     = ~src_q;
          state_d   = StSolve;
          cnt_d     = '0;
          x_d       = '0;
          y_d       = '0;
        end
      end
      default: state_d = StInit;
    endcase
    if (adv) begin
      cnt_d = cnt_q + 1'b1;
      if (x_q == LastX) begin
        x_d = '0;
        y_d = y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  // Moments of the cell just read.
  always_comb begin
    rho_w = '0;
    jx_w  = '0;
    jy_w  = '0;
    for (int i = 0; i < 9; i++) begin
      rho_w = rho_w + 48'(rd_f_q[i]);
      jx_w  = jx_w + 48'(EX[i]) * 48'(rd_f_q[i]);
      jy_w  = jy_w + 48'(EY[i]) * 48'(rd_f_q[i]);
    end
  end

  // Equilibrium bracket: rho + 3 e.j + 4.5 (e.j)^2 - 1.5 |j|^2, all in FRAC units.
  always_comb begin
    ej_v  = '0;
    sq_w  = '0;
    usq_w = ((48'(mom_jx_q) * 48'(mom_jx_q)) >>> FRAC) +
            ((48'(mom_jy_q) * 48'(mom_jy_q)) >>> FRAC);
    t15_w = (48'sd3 * usq_w) >>> 1;
    for (int i = 0; i < 9; i++) begin
      ej_v     = sat18(48'(EX[i]) * 48'(mom_jx_q) + 48'(EY[i]) * 48'(mom_jy_q));
      sq_w     = (48'(ej_v) * 48'(ej_v)) >>> FRAC;
      brk_d[i] = sat18(48'(mom_rho_q) + 48'sd3 * 48'(ej_v) + ((48'sd9 * sq_w) >>> 1) - t15_w);
    end
  end

  // Weight the bracket to obtain each equilibrium distribution.
  always_comb begin
    for (int i = 0; i < 9; i++) begin
      feq_d[i] = sat18((48'(W[i]) * 48'(brk_q[i])) >>> FRAC);
    end
  end

  // Streaming targets with periodic wrap on every edge.
  always_comb begin
    sx = '0;
    sy = '0;
    for (int i = 0; i < 9; i++) begin
      if (EX[i] > 0)      sx = (out_x_q == LastX) ? '0 : out_x_q + 1'b1;
      else if (EX[i] < 0) sx = (out_x_q == '0) ? LastX : out_x_q - 1'b1;
      else                sx = out_x_q;
      if (EY[i] > 0)      sy = (out_y_q == LastY) ? '0 : out_y_q + 1'b1;
      else if (EY[i] < 0) sy = (out_y_q == '0) ? LastY : out_y_q - 1'b1;
      else                sy = out_y_q;
      st_addr[i] = cell_addr(sx, sy);
    end
  end

  // Solver pipeline registers; a reset flushes any step in flight.
  always_ff @(posedge clk_50 or negedge reset) begin
    if (!reset) begin
      rd_vld_q  <= 1'b0;
      mom_vld_q <= 1'b0;
      brk_vld_q <= 1'b0;
      out_vld_q <= 1'b0;
      rd_x_q    <= '0;
      rd_y_q    <= '0;
      mom_x_q   <= '0;
      mom_y_q   <= '0;
      brk_x_q   <= '0;
      brk_y_q   <= '0;
      out_x_q   <= '0;
      out_y_q   <= '0;
      mom_rho_q <= '0;
      mom_jx_q  <= '0;
      mom_jy_q  <= '0;
      brk_rho_q <= '0;
      out_rho_q <= '0;
      for (int i = 0; i < 9; i++) begin
        rd_f_q[i] <= '0;
        brk_q[i]  <= '0;
        feq_q[i]  <= '0;
      end
    end else begin
      rd_vld_q <= issue;
      rd_x_q   <= x_q;
      rd_y_q   <= y_q;
      if (issue) begin
        for (int i = 0; i < 9; i++) rd_f_q[i] <= f_mem[src_q][i][cnt_q[AddrW-1:0]];
      end
      mom_vld_q <= rd_vld_q;
      mom_x_q   <= rd_x_q;
      mom_y_q   <= rd_y_q;
      mom_rho_q <= sat18(rho_w);
      mom_jx_q  <= sat18(jx_w);
      mom_jy_q  <= sat18(jy_w);
      brk_vld_q <= mom_vld_q;
      brk_x_q   <= mom_x_q;
      brk_y_q   <= mom_y_q;
      brk_rho_q <= mom_rho_q;
      out_vld_q <= brk_vld_q;
      out_x_q   <= brk_x_q;
      out_y_q   <= brk_y_q;
      out_rho_q <= brk_rho_q;
      for (int i = 0; i < 9; i++) begin
        brk_q[i] <= brk_d[i];
        feq_q[i] <= feq_d[i];
      end
    end
  end

  // Bank RAM writes: INIT fills bank A, SOLVE streams into the destination bank.
  always_ff @(posedge clk_50) begin
    if (state_q == StInit) begin
      for (int i = 0; i < 9; i++) begin
        f_mem[0][i][cnt_q[AddrW-1:0]] <= ((x_q == MidX) && (y_q == MidY)) ? Ctr[i] : W[i];
      end
      rho_mem[0][cnt_q[AddrW-1:0]] <= ((x_q == MidX) && (y_q == MidY)) ? RhoCtr : RhoRest;
    end
    if (out_vld_q) begin
      for (int i = 0; i < 9; i++) f_mem[dst][i][st_addr[i]] <= feq_q[i];
      rho_mem[dst][cell_addr(out_x_q, out_y_q)] <= out_rho_q;
    end
  end

  // Pixel to cell lookup and rho to intensity mapping.
  always_comb begin
    in_range  = (iCoord_X < 10'd640) && (iCoord_Y < 10'd480);
    disp_addr = in_range ? cell_addr(iCoord_X[9:5], iCoord_Y[8:5]) : '0;
    disp_rho  = rho_mem[disp_q][disp_addr];
    if (disp_rho < 0)                inten = 8'd0;
    else if (disp_rho >= 18'sd16384) inten = 8'd255;
    else                             inten = disp_rho[13:6];
  end

  // Registered colour output, black outside the visible area.
  always_ff @(posedge clk_50 or negedge reset) begin
    if (!reset) begin
      oRed   <= 8'd0;
      oGreen <= 8'd0;
      oBlue  <= 8'd0;
    end else if (in_range) begin
      oRed   <= inten;
      oGreen <= inten;
      oBlue  <= 8'd255 - inten;
    end else begin
      oRed   <= 8'd0;
      oGreen <= 8'd0;
      oBlue  <= 8'd0;
    end
  end

endmodule

// File: tb/tb_memory_lbm_lattice.sv
// Self-checking bench for memory_lbm_lattice with a whole-lattice reference model.
module tb_memory_lbm_lattice;

  localparam int NX   = 20;
  localparam int NY   = 15;
  localparam int NC   = NX * NY;
  localparam int FRAC = 13;

  logic       clk_50 = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] iCoord_X = '0;
  logic [9:0] iCoord_Y = '0;
  logic       vga_done = 1'b0;
  logic [7:0] oRed, oGreen, oBlue;

  int checks = 0;
  int failures = 0;

  int ext [9] = '{0, 1, 0, -1, 0, 1, -1, -1, 1};
  int eyt [9] = '{0, 0, 1, 0, -1, 1, 1, -1, -1};
  int wt  [9] = '{3641, 910, 910, 910, 910, 228, 228, 228, 228};

  // Model lattice: current source state and the rho the display should show.
  int f_cur [9][NC];
  int f_nxt [9][NC];
  int disp_rho [NC];
  int new_rho [NC];

  memory_lbm_lattice dut (
    .clk_50   (clk_50),
    .reset    (reset),
    .iCoord_X (iCoord_X),
    .iCoord_Y (iCoord_Y),
    .vga_done (vga_done),
    .oRed     (oRed),
    .oGreen   (oGreen),
    .oBlue    (oBlue)
  );

  always #10 clk_50 = ~clk_50;

  function automatic longint sat18(input longint v);
    if (v > 131071) return 131071;
    if (v < -131072) return -131072;
    return v;
  endfunction

  function automatic logic [23:0] colour(input int rho);
    int inten;
    if (rho < 0) inten = 0;
    else if (rho >= 16384) inten = 255;
    else inten = (rho >> 6) & 255;
    return {8'(inten), 8'(inten), 8'(255 - inten)};
  endfunction

  task automatic model_init();
    int s;
    for (int c = 0; c < NC; c++) begin
      s = 0;
      for (int i = 0; i < 9; i++) begin
        if (c == 7 * NX + 10) f_cur[i][c] = (i == 0) ? 5461 : ((i < 5) ? 1365 : 341);
        else f_cur[i][c] = wt[i];
        s += f_cur[i][c];
      end
      disp_rho[c] = s;
    end
  endtask

  // One full lattice step: omega = 1 collision then periodic streaming.
  task automatic model_solve();
    int c, nx, ny;
    longint rho, jx, jy, usq, ej, br;
    for (int y = 0; y < NY; y++) begin
      for (int x = 0; x < NX; x++) begin
        c = y * NX + x;
        rho = 0;
        jx = 0;
        jy = 0;
        for (int i = 0; i < 9; i++) begin
          rho += f_cur[i][c];
          jx += ext[i] * f_cur[i][c];
          jy += eyt[i] * f_cur[i][c];
        end
        rho = sat18(rho);
        jx = sat18(jx);
        jy = sat18(jy);
        new_rho[c] = int'(rho);
        usq = ((jx * jx) >>> FRAC) + ((jy * jy) >>> FRAC);
        for (int i = 0; i < 9; i++) begin
          ej = sat18(ext[i] * jx + eyt[i] * jy);
          br = sat18(rho + 3 * ej + ((9 * ((ej * ej) >>> FRAC)) >>> 1) - ((3 * usq) >>> 1));
          nx = (x + ext[i] + NX) % NX;
          ny = (y + eyt[i] + NY) % NY;
          f_nxt[i][ny * NX + nx] = int'(sat18((wt[i] * br) >>> FRAC));
        end
      end
    end
    f_cur = f_nxt;
    disp_rho = new_rho;
  endtask

  task automatic read_pixel(input int x, input int y, output logic [23:0] rgb);
    @(negedge clk_50);
    iCoord_X = 10'(x);
    iCoord_Y = 10'(y);
    @(posedge clk_50);
    #1;
    rgb = {oRed, oGreen, oBlue};
  endtask

  task automatic pulse_done();
    repeat ($urandom_range(0, 15)) @(negedge clk_50);
    @(negedge clk_50);
    vga_done = 1'b1;
    @(negedge clk_50);
    vga_done = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk_50);
    reset = 1'b0;
    repeat (3) @(negedge clk_50);
    reset = 1'b1;
    model_init();
  endtask

  // Scans every cell at a random pixel inside it and compares with the model.
  task automatic check_lattice(input string name);
    int bad, first;
    logic [23:0] got, first_got, first_exp;
    bad = 0;
    first = -1;
    first_got = '0;
    first_exp = '0;
    for (int c = 0; c < NC; c++) begin
      read_pixel((c % NX) * 32 + $urandom_range(0, 31), (c / NX) * 32 + $urandom_range(0, 31),
                 got);
      if (got !== colour(disp_rho[c])) begin
        bad++;
        if (first < 0) begin
          first = c;
          first_got = got;
          first_exp = colour(disp_rho[c]);
        end
      end
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL %s: %0d cells differ, cell %0d got %h expected %h", name, bad, first,
               first_got, first_exp);
    end
  endtask

  task automatic test_reset();
    iCoord_X = 10'd330;
    iCoord_Y = 10'd230;
    #25;
    reset = 1'b0;
    #1;
    checks++;
    if ({oRed, oGreen, oBlue} !== 24'h0) begin
      failures++;
      $display("FAIL reset_async: got %h expected 000000", {oRed, oGreen, oBlue});
    end
    repeat (3) @(posedge clk_50);
    #1;
    checks++;
    if ({oRed, oGreen, oBlue} !== 24'h0) begin
      failures++;
      $display("FAIL reset_hold: got %h expected 000000", {oRed, oGreen, oBlue});
    end
    @(negedge clk_50);
    reset = 1'b1;
    model_init();
  endtask

  task automatic test_init_display();
    logic [23:0] got;
    int c;
    repeat (398) @(posedge clk_50);
    read_pixel(0, 0, got);
    checks++;
    if (got !== 24'h80807F) begin
      failures++;
      $display("FAIL pixel_0_0: got %h expected 80807f", got);
    end
    read_pixel(330, 230, got);
    checks++;
    if (got !== 24'hBFBF40) begin
      failures++;
      $display("FAIL pixel_center: got %h expected bfbf40", got);
    end
    c = $urandom_range(0, NC - 1);
    read_pixel((c % NX) * 32 + $urandom_range(0, 31), (c / NX) * 32 + $urandom_range(0, 31), got);
    checks++;
    if (got !== colour(disp_rho[c])) begin
      failures++;
      $display("FAIL pixel_random cell %0d: got %h expected %h", c, got, colour(disp_rho[c]));
    end
  endtask

  task automatic test_out_of_range();
    logic [23:0] got;
    int xs [6];
    int ys [6];
    xs = '{700, 100, 640, 0, 0, 0};
    ys = '{100, 490, 0, 480, 0, 0};
    xs[4] = $urandom_range(640, 1023);
    ys[4] = $urandom_range(0, 1023);
    xs[5] = $urandom_range(0, 1023);
    ys[5] = $urandom_range(480, 1023);
    for (int k = 0; k < 6; k++) begin
      read_pixel(xs[k], ys[k], got);
      checks++;
      if (got !== 24'h0) begin
        failures++;
        $display("FAIL off_screen (%0d,%0d): got %h expected 000000", xs[k], ys[k], got);
      end
    end
    read_pixel(639, 479, got);
    checks++;
    if (got !== colour(disp_rho[NC - 1])) begin
      failures++;
      $display("FAIL corner_pixel: got %h expected %h", got, colour(disp_rho[NC - 1]));
    end
  endtask

  task automatic test_first_step();
    repeat (400) @(posedge clk_50);
    model_solve();
    check_lattice("first_step");
  endtask

  task automatic test_steps();
    for (int k = 0; k < 5; k++) begin
      pulse_done();
      repeat (400) @(posedge clk_50);
      model_solve();
      check_lattice($sformatf("step_%0d", k + 2));
    end
  endtask

  task automatic test_back_to_back();
    pulse_done();
    repeat (20) @(posedge clk_50);
    for (int k = 0; k < 3; k++) begin
      pulse_done();
      repeat ($urandom_range(20, 50)) @(posedge clk_50);
    end
    repeat (900) @(posedge clk_50);
    model_solve();
    model_solve();
    check_lattice("pending_collapse");
  endtask

  task automatic test_reset_mid_solve();
    logic [23:0] got;
    do_reset();
    repeat (450) @(posedge clk_50);
    read_pixel(0, 0, got);
    checks++;
    if (got !== 24'h80807F) begin
      failures++;
      $display("FAIL pre_reset_pixel: got %h expected 80807f", got);
    end
    @(posedge clk_50);
    #3;
    reset = 1'b0;
    #1;
    checks++;
    if ({oRed, oGreen, oBlue} !== 24'h0) begin
      failures++;
      $display("FAIL mid_solve_reset: got %h expected 000000", {oRed, oGreen, oBlue});
    end
    repeat (3) @(negedge clk_50);
    reset = 1'b1;
    model_init();
    repeat (398) @(posedge clk_50);
    read_pixel(0, 0, got);
    checks++;
    if (got !== 24'h80807F) begin
      failures++;
      $display("FAIL reinit_pixel_0_0: got %h expected 80807f", got);
    end
    read_pixel(330, 230, got);
    checks++;
    if (got !== 24'hBFBF40) begin
      failures++;
      $display("FAIL reinit_center: got %h expected bfbf40", got);
    end
    repeat (400) @(posedge clk_50);
    model_solve();
    check_lattice("reinit_first_step");
    pulse_done();
    repeat (400) @(posedge clk_50);
    model_solve();
    check_lattice("reinit_second_step");
  endtask

  task automatic test_free_run_251();
    logic [23:0] got;
    int y;
    do_reset();
    for (int k = 0; k < 9; k++) begin
      repeat (250) @(posedge clk_50);
      @(negedge clk_50);
      vga_done = 1'b1;
      @(negedge clk_50);
      vga_done = 1'b0;
    end
    repeat (1200) @(posedge clk_50);
    read_pixel(0, 0, got);
    checks++;
    if (got !== 24'h80807F) begin
      failures++;
      $display("FAIL free_run_pixel_0_0: got %h expected 80807f", got);
    end
    y = $urandom_range(0, NY - 1);
    read_pixel($urandom_range(0, 31), y * 32 + $urandom_range(0, 31), got);
    checks++;
    if (got !== 24'h80807F) begin
      failures++;
      $display("FAIL free_run_column0 row %0d: got %h expected 80807f", y, got);
    end
  endtask

  initial begin
    test_reset();
    test_init_display();
    test_out_of_range();
    test_first_step();
    test_steps();
    test_back_to_back();
    test_reset_mid_solve();
    test_free_run_251();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
